// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Sequencing controller for a 4-bit ALU built around an
//               external full_adder_4bit.
//               Supported operations:
//                 - ADD
//                 - SUB
//                 - ACC (running accumulator)
//                 - optional shift-add MUL
//               Build option: define ALU_SEQ_MUL_EN to include the
//               multiplier (P register and iteration counter). Without it,
//               op=10 completes after one EXEC cycle with result 0 and
//               ovf=1.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl (
    input  logic       clkin_50,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [3:0] opa,
    input  logic [3:0] opb,
    input  logic [3:0] add_sum,
    input  logic       add_cout,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_cin,
    output logic [7:0] result,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    input  logic       acc_clr
);

    localparam logic [1:0] C_OP_ADD = 2'b00;
    localparam logic [1:0] C_OP_SUB = 2'b01;
    localparam logic [1:0] C_OP_MUL = 2'b10;
    localparam logic [1:0] C_OP_ACC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_acc;
    logic [7:0] r_result;
    logic       r_ovf;
    logic       w_exec_last;
    logic [7:0] w_res_next;
    logic       w_ovf_next;
    logic       w_accept;

`ifdef ALU_SEQ_MUL_EN
    logic [7:0] r_p;
    logic [1:0] r_cnt;
    logic [7:0] w_p_next;
`endif

    assign w_accept = (r_state == ST_IDLE) && start;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign result   = r_result;
    assign ovf      = r_ovf;

    // Next-state logic plus adder drive and the result about to be captured
    always_comb begin
        w_state_next = r_state;
        add_a        = 4'h0;
        add_b        = 4'h0;
        add_cin      = 1'b0;
        w_exec_last  = 1'b0;
        w_res_next   = 8'h00;
        w_ovf_next   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        w_p_next     = r_p;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (r_op)
                    C_OP_ADD: begin
                        add_a       = r_a;
                        add_b       = r_b;
                        w_res_next  = {3'b000, add_cout, add_sum};
                        w_ovf_next  = add_cout;
                        w_exec_last = 1'b1;
                    end
                    C_OP_SUB: begin
                        // A + ~B + 1; a missing carry-out means a borrow
                        add_a       = r_a;
                        add_b       = ~r_b;
                        add_cin     = 1'b1;
                        w_res_next  = {4'h0, add_sum};
                        w_ovf_next  = ~add_cout;
                        w_exec_last = 1'b1;
                    end
                    C_OP_ACC: begin
                        add_a       = r_acc;
                        add_b       = r_a;
                        w_res_next  = {3'b000, add_cout, add_sum};
                        w_ovf_next  = add_cout;
                        w_exec_last = 1'b1;
                    end
                    C_OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                        // One shift-add step: add A into the upper half if the
                        // current multiplier LSB is set, then shift right.
                        add_a       = r_p[7:4];
                        add_b       = r_p[0] ? r_a : 4'h0;
                        w_p_next    = {add_cout, add_sum, r_p[3:1]};
                        w_res_next  = w_p_next;
                        w_ovf_next  = 1'b0;
                        w_exec_last = (r_cnt == 2'd3);
`else
                        // Multiplier not built: flag the op as unsupported
                        w_res_next  = 8'h00;
                        w_ovf_next  = 1'b1;
                        w_exec_last = 1'b1;
`endif
                    end
                endcase
                if (w_exec_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture on accept; held stable for the whole operation
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= 2'b00;
            r_a  <= 4'h0;
            r_b  <= 4'h0;
        end else if (w_accept) begin
            r_op <= op;
            r_a  <= opa;
            r_b  <= opb;
        end
    end

    // Accumulator: clear has priority over an ACC load
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 4'h0;
        end else if (acc_clr) begin
            r_acc <= 4'h0;
        end else if ((r_state == ST_EXEC) && (r_op == C_OP_ACC)) begin
            r_acc <= add_sum;
        end
    end

    // Result and flag captured only on the edge that enters DONE
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= 8'h00;
            r_ovf    <= 1'b0;
        end else if ((r_state == ST_EXEC) && w_exec_last) begin
            r_result <= w_res_next;
            r_ovf    <= w_ovf_next;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    // Partial product and iteration counter for the shift-add multiplier
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= 8'h00;
            r_cnt <= 2'd0;
        end else if (w_accept) begin
            r_p   <= {4'h0, opb};
            r_cnt <= 2'd0;
        end else if ((r_state == ST_EXEC) && (r_op == C_OP_MUL)) begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + 2'd1;
        end
    end
`endif

endmodule
`default_nettype wire
